// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and constants for the fifo_top write-port arbiter.
//   arb_state_e : arbiter FSM states (IDLE = port free, BUSY = port owned)
//   PKT_CNT_W   : width of the completed-packet counter
//   idx_width() : bit width needed to index one of n requesters
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam int PKT_CNT_W = 16;

    // Index width for n lanes; never below 1 so a 1-bit grant id always exists.
    function automatic int idx_width(input int n);
        int w;
        w = (n <= 1) ? 1 : $clog2(n);
        return w;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker.
//   i_req     : NREQ-bit request vector
//   i_last_id : index of the previous winner; search starts just after it
//   o_any     : at least one request bit is set
//   o_pick_id : first set request scanning last_id+1, last_id+2, ... mod NREQ
// The request vector is doubled and shifted right so that the lane after
// last_id lands at bit 0; a priority encoder then finds the first set bit
// and the offset is mapped back to an absolute lane index.
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_last_id,
    output logic            o_any,
    output logic [IDW-1:0]  o_pick_id
);

    localparam logic [IDW+1:0] NREQ_W = (IDW+2)'(NREQ);

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [IDW+1:0]    w_start;
    logic [IDW+1:0]    w_k;
    logic [IDW+1:0]    w_sum;
    logic              w_found;

    // Rotate, priority-encode the lowest set bit, then fold back modulo NREQ.
    always_comb begin
        w_dbl   = {i_req, i_req};
        w_start = {2'b00, i_last_id} + {{(IDW+1){1'b0}}, 1'b1};
        w_rot   = NREQ'(w_dbl >> w_start);
        w_found = 1'b0;
        w_k     = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_k     = (IDW+2)'(k);
            end else begin
                w_found = w_found;
            end
        end
        // start <= NREQ and k < NREQ, so one subtraction is enough.
        w_sum = w_start + w_k;
        if (w_sum >= NREQ_W) begin
            w_sum = w_sum - NREQ_W;
        end else begin
            w_sum = w_sum;
        end
        o_any     = |i_req;
        o_pick_id = w_sum[IDW-1:0];
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares the fifo_top write port among NREQ packet requesters using
// round-robin arbitration with packet locking.
//   wclk, wrst_n : write clock, async active-low reset
//   cfg_en       : per-requester enable, looked at only when arbitrating
//   req_valid/last/data : per-lane beat, last flag and data (lane i at i*WSIZE)
//   req_ready    : lane i beat accepted this cycle
//   wfull        : fifo_top full flag (backpressure)
//   winc, wdata  : fifo_top write strobe and data
//   grant_valid  : port is owned (BUSY)
//   grant_id     : current / most recent owner
//   pkt_cnt      : packets completed since reset (wrapping)
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int WSIZE = 8,
    parameter  int NREQ  = 4,
    localparam int IDW   = idx_width(NREQ)
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       cfg_en,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*WSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [WSIZE-1:0]      wdata,
    output logic                  grant_valid,
    output logic [IDW-1:0]        grant_id,
    output logic [PKT_CNT_W-1:0]  pkt_cnt
);

    localparam logic [IDW-1:0] LAST_ID_RST = IDW'(NREQ - 1);

    arb_state_e            r_state;
    logic [IDW-1:0]        r_grant_id;
    logic [IDW-1:0]        r_last_id;
    logic [PKT_CNT_W-1:0]  r_pkt_cnt;

    logic [NREQ-1:0]       w_elig;
    logic                  w_any;
    logic [IDW-1:0]        w_pick_id;
    logic                  w_owner_valid;
    logic                  w_owner_last;
    logic [WSIZE-1:0]      w_owner_data;
    logic                  w_last_beat;

    assign w_elig        = req_valid & cfg_en;
    assign w_owner_valid = req_valid[r_grant_id];
    assign w_owner_last  = req_last[r_grant_id];
    assign w_owner_data  = req_data[r_grant_id*WSIZE +: WSIZE];
    assign w_last_beat   = winc & w_owner_last;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .i_req     (w_elig),
        .i_last_id (r_last_id),
        .o_any     (w_any),
        .o_pick_id (w_pick_id)
    );

    // Write-port mux: only the owner's lane reaches fifo_top, and only in BUSY.
    always_comb begin
        winc      = 1'b0;
        wdata     = '0;
        req_ready = '0;
        if (r_state == ST_BUSY) begin
            winc                  = w_owner_valid & ~wfull;
            wdata                 = w_owner_data;
            req_ready[r_grant_id] = ~wfull;
        end else begin
            winc      = 1'b0;
            wdata     = '0;
            req_ready = '0;
        end
    end

    // Arbiter FSM: grab the port in IDLE, release it after the owner's last beat.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state    <= ST_IDLE;
            r_grant_id <= '0;
            r_last_id  <= LAST_ID_RST;
            r_pkt_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant_id <= w_pick_id;
                        r_state    <= ST_BUSY;
                    end else begin
                        r_state    <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // Grant survives wfull, dropped valid and cleared cfg_en.
                    if (w_last_beat) begin
                        r_state   <= ST_IDLE;
                        r_last_id <= r_grant_id;
                        r_pkt_cnt <= r_pkt_cnt + PKT_CNT_W'(1);
                    end else begin
                        r_state   <= ST_BUSY;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_valid = (r_state == ST_BUSY);
    assign grant_id    = r_grant_id;
    assign pkt_cnt     = r_pkt_cnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter (WSIZE=8, NREQ=4): a table of
// per-cycle vectors plus hand-written round-robin and reset sequences.
// Inputs change on the falling edge; outputs are checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    typedef struct {
        logic        rst;
        logic [3:0]  cfg;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        wfull;
        logic        e_winc;
        logic [7:0]  e_wdata;
        logic [3:0]  e_ready;
        logic        e_gv;
        logic [1:0]  e_gid;
        logic [15:0] e_pkt;
    } vec_t;

    logic        wclk;
    logic        wrst_n;
    logic [3:0]  cfg_en;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        wfull;
    logic        winc;
    logic [7:0]  wdata;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic [15:0] pkt_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  p_valid = 4'b0000;
    logic [3:0]  p_ready = 4'b0000;
    logic [3:0]  p_last  = 4'b0000;
    logic [31:0] p_data  = 32'h0;

    vec_t        tbl[$];
    logic [1:0]  o;
    logic [3:0]  lv;
    logic [7:0]  ed;

    fifo_wr_arbiter #(
        .WSIZE (8),
        .NREQ  (4)
    ) dut (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .cfg_en      (cfg_en),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .wfull       (wfull),
        .winc        (winc),
        .wdata       (wdata),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .pkt_cnt     (pkt_cnt)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of requester inputs; stalled lanes must keep data and last.
    task automatic drive(input logic [3:0] cfg, input logic [3:0] v, input logic [3:0] l,
                         input logic [31:0] d, input logic wf);
        for (int i = 0; i < 4; i++) begin
            if (p_valid[i] && !p_ready[i] && v[i]) begin
                chk($sformatf("proto lane%0d", i), {l[i], d[i*8 +: 8]}, {p_last[i], p_data[i*8 +: 8]});
            end
        end
        cfg_en    = cfg;
        req_valid = v;
        req_last  = l;
        req_data  = d;
        wfull     = wf;
        #1;
        p_valid = v;
        p_last  = l;
        p_data  = d;
        p_ready = req_ready;
    endtask

    task automatic do_reset();
        @(negedge wclk);
        wrst_n = 1'b0;
        drive(4'hF, 4'h0, 4'h0, 32'h0, 1'b0);
        chk("reset grant_valid", {31'b0, grant_valid}, 32'd0);
        chk("reset grant_id", {30'b0, grant_id}, 32'd0);
        chk("reset pkt_cnt", {16'b0, pkt_cnt}, 32'd0);
        chk("reset winc", {31'b0, winc}, 32'd0);
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic rst, input logic [3:0] cfg, input logic [3:0] v,
                                input logic [3:0] l, input logic [31:0] d, input logic wf,
                                input logic ew, input logic [7:0] ewd, input logic [3:0] er,
                                input logic egv, input logic [1:0] egid, input logic [15:0] ep);
        vec_t r;
        r.rst = rst; r.cfg = cfg; r.valid = v; r.last = l; r.data = d; r.wfull = wf;
        r.e_winc = ew; r.e_wdata = ewd; r.e_ready = er; r.e_gv = egv; r.e_gid = egid; r.e_pkt = ep;
        return r;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        if (v.rst) begin
            do_reset();
        end
        drive(v.cfg, v.valid, v.last, v.data, v.wfull);
        chk($sformatf("row%0d winc", idx), {31'b0, winc}, {31'b0, v.e_winc});
        chk($sformatf("row%0d req_ready", idx), {28'b0, req_ready}, {28'b0, v.e_ready});
        chk($sformatf("row%0d grant_valid", idx), {31'b0, grant_valid}, {31'b0, v.e_gv});
        chk($sformatf("row%0d grant_id", idx), {30'b0, grant_id}, {30'b0, v.e_gid});
        chk($sformatf("row%0d pkt_cnt", idx), {16'b0, pkt_cnt}, {16'b0, v.e_pkt});
        if (v.e_winc) begin
            chk($sformatf("row%0d wdata", idx), {24'b0, wdata}, {24'b0, v.e_wdata});
        end
        @(negedge wclk);
    endtask

    initial begin
        wrst_n    = 1'b0;
        cfg_en    = 4'hF;
        req_valid = 4'h0;
        req_last  = 4'h0;
        req_data  = 32'h0;
        wfull     = 1'b0;

        // Test 1: single requester, 3-beat packet 0x10..0x12.
        tbl.push_back(mk(1'b1, 4'hF, 4'b0001, 4'b0000, 32'h10, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 16'd0));
        tbl.push_back(mk(1'b0, 4'hF, 4'b0001, 4'b0000, 32'h10, 1'b0, 1'b1, 8'h10, 4'b0001, 1'b1, 2'd0, 16'd0));
        tbl.push_back(mk(1'b0, 4'hF, 4'b0001, 4'b0000, 32'h11, 1'b0, 1'b1, 8'h11, 4'b0001, 1'b1, 2'd0, 16'd0));
        tbl.push_back(mk(1'b0, 4'hF, 4'b0001, 4'b0001, 32'h12, 1'b0, 1'b1, 8'h12, 4'b0001, 1'b1, 2'd0, 16'd0));
        tbl.push_back(mk(1'b0, 4'hF, 4'b0000, 4'b0000, 32'h12, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 16'd1));
        // Test 3: owner 2 stalled by wfull for 5 cycles.
        tbl.push_back(mk(1'b1, 4'hF, 4'b0100, 4'b0000, 32'h00300000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 16'd0));
        tbl.push_back(mk(1'b0, 4'hF, 4'b0100, 4'b0000, 32'h00300000, 1'b0, 1'b1, 8'h30, 4'b0100, 1'b1, 2'd2, 16'd0));
        for (int i = 0; i < 5; i++) begin
            tbl.push_back(mk(1'b0, 4'hF, 4'b0100, 4'b0000, 32'h00310000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b1, 2'd2, 16'd0));
        end
        tbl.push_back(mk(1'b0, 4'hF, 4'b0100, 4'b0000, 32'h00310000, 1'b0, 1'b1, 8'h31, 4'b0100, 1'b1, 2'd2, 16'd0));
        tbl.push_back(mk(1'b0, 4'hF, 4'b0100, 4'b0100, 32'h00320000, 1'b0, 1'b1, 8'h32, 4'b0100, 1'b1, 2'd2, 16'd0));
        tbl.push_back(mk(1'b0, 4'hF, 4'b0000, 4'b0000, 32'h00320000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2, 16'd1));
        // Test 4: cfg_en=1010 alternates 1/3; cfg_en[1] cleared while 1 owns.
        tbl.push_back(mk(1'b1, 4'hA, 4'hF, 4'b1111, 32'h43424140, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 16'd0));
        tbl.push_back(mk(1'b0, 4'hA, 4'hF, 4'b1111, 32'h43424140, 1'b0, 1'b1, 8'h41, 4'b0010, 1'b1, 2'd1, 16'd0));
        tbl.push_back(mk(1'b0, 4'hA, 4'hF, 4'b1101, 32'h43424140, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1, 16'd1));
        tbl.push_back(mk(1'b0, 4'hA, 4'hF, 4'b1101, 32'h43424140, 1'b0, 1'b1, 8'h43, 4'b1000, 1'b1, 2'd3, 16'd1));
        tbl.push_back(mk(1'b0, 4'hA, 4'hF, 4'b1101, 32'h43424140, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd3, 16'd2));
        tbl.push_back(mk(1'b0, 4'h8, 4'hF, 4'b1101, 32'h43424140, 1'b0, 1'b1, 8'h41, 4'b0010, 1'b1, 2'd1, 16'd2));
        tbl.push_back(mk(1'b0, 4'h8, 4'hF, 4'b1111, 32'h43424440, 1'b0, 1'b1, 8'h44, 4'b0010, 1'b1, 2'd1, 16'd2));
        tbl.push_back(mk(1'b0, 4'h8, 4'hF, 4'b1111, 32'h43424440, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1, 16'd3));
        tbl.push_back(mk(1'b0, 4'h8, 4'hF, 4'b1111, 32'h43424440, 1'b0, 1'b1, 8'h43, 4'b1000, 1'b1, 2'd3, 16'd3));
        tbl.push_back(mk(1'b0, 4'h8, 4'h0, 4'b0000, 32'h43424440, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd3, 16'd4));
        // Test 5: owner 0 drops valid 3 cycles while requester 1 waits.
        tbl.push_back(mk(1'b1, 4'hF, 4'b0011, 4'b0010, 32'h00006050, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 16'd0));
        tbl.push_back(mk(1'b0, 4'hF, 4'b0011, 4'b0010, 32'h00006050, 1'b0, 1'b1, 8'h50, 4'b0001, 1'b1, 2'd0, 16'd0));
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(mk(1'b0, 4'hF, 4'b0010, 4'b0010, 32'h00006051, 1'b0, 1'b0, 8'h00, 4'b0001, 1'b1, 2'd0, 16'd0));
        end
        tbl.push_back(mk(1'b0, 4'hF, 4'b0011, 4'b0011, 32'h00006051, 1'b0, 1'b1, 8'h51, 4'b0001, 1'b1, 2'd0, 16'd0));
        tbl.push_back(mk(1'b0, 4'hF, 4'b0010, 4'b0010, 32'h00006051, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 16'd1));
        tbl.push_back(mk(1'b0, 4'hF, 4'b0010, 4'b0010, 32'h00006051, 1'b0, 1'b1, 8'h60, 4'b0010, 1'b1, 2'd1, 16'd1));
        tbl.push_back(mk(1'b0, 4'hF, 4'b0000, 4'b0000, 32'h00006051, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1, 16'd2));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Test 2: all four requesters, 2-beat packets, two full rounds.
        do_reset();
        for (int p = 0; p < 8; p++) begin
            o  = 2'(p % 4);
            ed = 8'hA0 + {6'b0, o};
            drive(4'hF, 4'hF, 4'h0, 32'hA3A2A1A0, 1'b0);
            chk($sformatf("t2 pkt%0d bubble grant_valid", p), {31'b0, grant_valid}, 32'd0);
            chk($sformatf("t2 pkt%0d bubble winc", p), {31'b0, winc}, 32'd0);
            chk($sformatf("t2 pkt%0d pkt_cnt", p), {16'b0, pkt_cnt}, p);
            @(negedge wclk);
            for (int b = 0; b < 2; b++) begin
                lv = (b == 1) ? (4'b0001 << o) : 4'b0000;
                drive(4'hF, 4'hF, lv, 32'hA3A2A1A0, 1'b0);
                chk($sformatf("t2 pkt%0d beat%0d grant_id", p, b), {30'b0, grant_id}, {30'b0, o});
                chk($sformatf("t2 pkt%0d beat%0d winc", p, b), {31'b0, winc}, 32'd1);
                chk($sformatf("t2 pkt%0d beat%0d wdata", p, b), {24'b0, wdata}, {24'b0, ed});
                chk($sformatf("t2 pkt%0d beat%0d req_ready", p, b), {28'b0, req_ready}, {28'b0, 4'b0001 << o});
                @(negedge wclk);
            end
        end
        drive(4'hF, 4'h0, 4'h0, 32'hA3A2A1A0, 1'b0);
        chk("t2 final pkt_cnt", {16'b0, pkt_cnt}, 32'd8);
        chk("t2 final grant_valid", {31'b0, grant_valid}, 32'd0);
        @(negedge wclk);

        // Test 6: reset asserted mid-packet.
        do_reset();
        drive(4'hF, 4'b0010, 4'b0010, 32'h00007100, 1'b0);
        @(negedge wclk);
        drive(4'hF, 4'b0010, 4'b0010, 32'h00007100, 1'b0);
        chk("t6 first winc", {31'b0, winc}, 32'd1);
        @(negedge wclk);
        drive(4'hF, 4'b0100, 4'b0000, 32'h00720000, 1'b0);
        chk("t6 pkt_cnt before", {16'b0, pkt_cnt}, 32'd1);
        @(negedge wclk);
        drive(4'hF, 4'b0100, 4'b0000, 32'h00720000, 1'b0);
        chk("t6 owner2 grant_id", {30'b0, grant_id}, 32'd2);
        chk("t6 owner2 wdata", {24'b0, wdata}, 32'h72);
        @(negedge wclk);
        wrst_n = 1'b0;
        drive(4'hF, 4'hF, 4'h0, 32'h73747170, 1'b0);
        chk("t6 rst grant_valid", {31'b0, grant_valid}, 32'd0);
        chk("t6 rst pkt_cnt", {16'b0, pkt_cnt}, 32'd0);
        chk("t6 rst winc", {31'b0, winc}, 32'd0);
        chk("t6 rst req_ready", {28'b0, req_ready}, 32'd0);
        @(negedge wclk);
        wrst_n = 1'b1;
        drive(4'hF, 4'hF, 4'h0, 32'h73747170, 1'b0);
        chk("t6 post idle grant_valid", {31'b0, grant_valid}, 32'd0);
        @(negedge wclk);
        drive(4'hF, 4'hF, 4'h0, 32'h73747170, 1'b0);
        chk("t6 post grant_valid", {31'b0, grant_valid}, 32'd1);
        chk("t6 post grant_id", {30'b0, grant_id}, 32'd0);
        chk("t6 post winc", {31'b0, winc}, 32'd1);
        chk("t6 post wdata", {24'b0, wdata}, 32'h70);
        @(negedge wclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the single write port of fifo_top among NREQ packet-oriented requesters in the write clock domain. Uses round-robin arbitration with packet locking: once granted, a requester keeps the port until it writes a beat flagged last. Drives fifo_top winc/wdata directly and honours wfull as backpressure. Sits between write-side producers and the FIFO; the read side is untouched.

Parameters:
WSIZE, 8, data width; must match fifo_top WSIZE.
NREQ, 4, number of requesters, 2..16.
IDW, $clog2(NREQ), grant index width (derived localparam, not overridable).

Ports:
wclk  in  1  write-domain clock; same clock as fifo_top wclk
wrst_n  in  1  asynchronous active-low reset
cfg_en  in  NREQ  per-requester enable; sampled only at arbitration
req_valid  in  NREQ  requester i has a beat on its data lane
req_last  in  NREQ  beat on lane i is last of packet
req_data  in  NREQ*WSIZE  lane i occupies bits [i*WSIZE +: WSIZE]
req_ready  out  NREQ  beat on lane i accepted this cycle
wfull  in  1  fifo_top full flag
winc  out  1  fifo_top write strobe
wdata  out  WSIZE  fifo_top write data
grant_valid  out  1  a requester owns the port (state BUSY)
grant_id  out  IDW  index of the current/last owner
pkt_cnt  out  16  packets completed since reset, wraps at 65535->0

Behaviour:
- Reset (async assert, release on wclk): state IDLE, last_id=NREQ-1 (first pick favours 0), grant_valid=0, grant_id=0, pkt_cnt=0. winc=0 and req_ready=0 combinationally while in IDLE.
- Elig = req_valid & cfg_en.
- IDLE: if elig!=0, pick the first set bit scanning last_id+1, +2, ... mod NREQ. Register owner into grant_id and go BUSY next cycle. No beat transfers in IDLE.
- BUSY, combinational outputs:
  - winc = req_valid[grant_id] & ~wfull
  - wdata = lane grant_id
  - req_ready[grant_id] = ~wfull; all other ready bits = 0
  - Beat accepted when winc=1.
- BUSY transitions: on an accepted beat with req_last[grant_id]=1, go IDLE next cycle, set last_id=grant_id and increment pkt_cnt. Otherwise stay BUSY.
- Latency: first beat transfers no earlier than 1 cycle after valid is seen in IDLE. One idle bubble between packets. A single-beat packet occupies 2 cycles minimum.
- wfull=1 in BUSY: winc=0 and ready=0; grant is held indefinitely with no timeout.
- Owner drops valid mid-packet: grant held, no transfer, others wait.
- cfg_en change: affects only the next arbitration. Clearing the owner's enable mid-packet does not revoke the grant.
- grant_id holds its last value in IDLE. grant_valid is the authoritative ownership indicator.
- Non-owner valid/last/data are ignored, never dropped. Those requesters must hold valid until ready.
- Requester protocol: data and last stable while valid=1 and ready=0. Not checked by RTL; bench asserts it.
- Reset mid-packet: state returns to IDLE immediately, partial packet abandoned, pkt_cnt cleared. fifo_top is reset by the system alongside.
- pkt_cnt increments once per last beat, never for non-last beats.

Decomposition:
- Package fifo_arb_pkg:
  - state enum {IDLE, BUSY}
  - localparam PKT_CNT_W=16
  - function for the lane-select index width
- Sub-module rr_pick:
  - Purely combinational round-robin picker.
  - Inputs: NREQ-bit request vector, last_id.
  - Outputs: any, pick_id.
  - Implement as double-width vector rotate plus priority encode.
- Top holds state register, grant/last_id/pkt_cnt registers and the output mux.

Test Plan:
1. Reset, then req_valid=4'b0001, 3 beats 0x10,0x11,0x12 (last on 0x12) with wfull=0 -> first winc 1 cycle after valid; 3 consecutive winc; wdata 0x10..0x12; pkt_cnt=1; grant_valid falls the cycle after the last beat.
2. All four requesters valid, each sending 2-beat packets tagged 0xA0+i, repeated twice -> grant order 0,1,2,3,0,1,2,3; each packet contiguous; pkt_cnt=8; one bubble between packets.
3. Owner 2 mid-packet, force wfull=1 for 5 cycles -> winc=0 and req_ready=0 throughout; grant_id stays 2; after wfull=0, remaining beats transfer with no loss or duplication.
4. cfg_en=4'b1010 with all valid -> only requesters 1 and 3 granted, alternating. Then clear cfg_en[1] while 1 owns the port -> its packet completes, next grant goes to 3.
5. Owner 0 deasserts valid for 3 cycles mid-packet while requester 1 is valid -> no transfers, grant held on 0; 1 is granted only after 0's last beat.
6. Assert wrst_n=0 mid-packet for 1 cycle -> grant_valid=0, pkt_cnt=0, winc=0 immediately; after release, requester 0 is picked first.
